// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-requester (CPU M-stage "m", debug/DMA "d") arbiter for one
//            32-bit memory bus. Writes finish in the grant cycle. Reads take
//            two cycles: the grant cycle, then one RDWAIT cycle. Misaligned
//            requests are granted and flagged with exc, but they never
//            reach the bus.
// Options  : ARB_FIXED_PRIO_EN - when defined, m always wins. When undefined,
//            a round-robin pointer picks the winner.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        reset,

    // CPU M-stage requester
    input  logic        m_req,
    input  logic        m_we,
    input  logic [1:0]  m_size,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_gnt,
    output logic        m_rvalid,
    output logic        m_exc,
    output logic [31:0] m_rdata,

    // Debug / DMA requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_exc,
    output logic [31:0] d_rdata,

    // Memory bus
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    output logic        bus_rd,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RDWAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_any_req;
    logic        w_pick_d;      // 1: d wins this cycle, 0: m wins
    logic        w_grant;       // a grant happens this cycle
    logic        w_rd_launch;   // the grant starts a bus read
    logic        w_sel_we;
    logic [1:0]  w_sel_size;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_misaligned;

    logic        r_rd_owner_d;  // owner of the read in flight (1 = d)
    logic        r_m_rvalid;
    logic        r_d_rvalid;
    logic [31:0] r_m_rdata;
    logic [31:0] r_d_rdata;

    // Reserved size code, or an address offset that does not fit the size.
    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            c_SIZE_BYTE: bad = 1'b0;
            c_SIZE_HALF: bad = off[0];
            c_SIZE_WORD: bad = (off != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lanes touched by an aligned write.
    function automatic logic [3:0] f_byteen(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            c_SIZE_BYTE: be = 4'b0001 << off;
            c_SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            c_SIZE_WORD: be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Copy narrow write data onto every lane so that any enabled lane gets it.
    function automatic logic [31:0] f_replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        rep = data;
        case (size)
            c_SIZE_BYTE: rep = {4{data[7:0]}};
            c_SIZE_HALF: rep = {2{data[15:0]}};
            default:     rep = data;
        endcase
        return rep;
    endfunction

    assign w_any_req = m_req | d_req;
    assign w_grant   = (r_state == IDLE) && !reset && w_any_req;

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: d is served only when m is not asking.
    assign w_pick_d = d_req & ~m_req;
`else
    logic r_last_d;             // 1: d received the most recent grant

    // On a tie, grant the requester that was not served last.
    assign w_pick_d = d_req & (~m_req | ~r_last_d);

    // Round-robin pointer. Every grant moves it, faulting grants included.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d <= 1'b1;
        end else if (w_grant) begin
            r_last_d <= w_pick_d;
        end
    end
`endif

    // Route the winning requester's command into the shared datapath.
    assign w_sel_we     = w_pick_d ? d_we    : m_we;
    assign w_sel_size   = w_pick_d ? d_size  : m_size;
    assign w_sel_addr   = w_pick_d ? d_addr  : m_addr;
    assign w_sel_wdata  = w_pick_d ? d_wdata : m_wdata;
    assign w_misaligned = f_misaligned(w_sel_size, w_sel_addr[1:0]);

    // Next state and all combinational bus/grant outputs. Reset silences everything.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_launch = 1'b0;
        m_gnt       = 1'b0;
        d_gnt       = 1'b0;
        m_exc       = 1'b0;
        d_exc       = 1'b0;
        bus_addr    = 32'h0000_0000;
        bus_wdata   = 32'h0000_0000;
        bus_byteen  = 4'b0000;
        bus_rd      = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        m_gnt    = ~w_pick_d;
                        d_gnt    = w_pick_d;
                        bus_addr = {w_sel_addr[31:2], 2'b00};
                        if (w_misaligned) begin
                            m_exc = ~w_pick_d;
                            d_exc = w_pick_d;
                        end else if (w_sel_we) begin
                            bus_byteen = f_byteen(w_sel_size, w_sel_addr[1:0]);
                            bus_wdata  = f_replicate(w_sel_size, w_sel_wdata);
                        end else begin
                            bus_rd      = 1'b1;
                            w_rd_launch = 1'b1;
                            w_state_nxt = RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Remember which requester owns the read that is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_owner_d <= 1'b0;
        end else if (w_rd_launch) begin
            r_rd_owner_d <= w_pick_d;
        end
    end

    // Capture read data during RDWAIT and send a one-cycle rvalid to the owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_m_rdata  <= 32'h0000_0000;
            r_d_rdata  <= 32'h0000_0000;
        end else begin
            r_m_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            if (r_state == RDWAIT) begin
                if (r_rd_owner_d) begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= bus_rdata;
                end else begin
                    r_m_rvalid <= 1'b1;
                    r_m_rdata  <= bus_rdata;
                end
            end
        end
    end

    assign m_rvalid = r_m_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign m_rdata  = r_m_rdata;
    assign d_rdata  = r_d_rdata;

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports m_req, m_we  input  1 each  CPU M-stage request / write flag.
REQ-004 SHALL have ports m_size  input  2 (00 byte, 01 half, 10 word, 11 reserved), m_addr  input  32, m_wdata  input  32.
REQ-005 SHALL have ports m_gnt, m_rvalid, m_exc  output  1 each, and m_rdata  output  32.
REQ-006 SHALL have a second requester port set with prefix d_ (debug/DMA), identical in names, widths and meaning to REQ-003..REQ-005.
REQ-007 SHALL have ports bus_addr  output  32, bus_wdata  output  32, bus_byteen  output  4, bus_rd  output  1, bus_rdata  input  32 (valid the cycle after bus_rd).

Function
REQ-008 SHALL implement FSM states IDLE and RDWAIT.
REQ-009 In IDLE, with any req high, SHALL grant exactly one requester combinationally (gnt high that cycle).
REQ-010 In RDWAIT, SHALL hold all gnt low, bus_byteen 0000 and bus_rd 0.
REQ-011 Both requesting in IDLE: SHALL grant the requester not granted last (round-robin pointer); pointer SHALL update on every grant, including faulting grants.
REQ-012 Grant cycle SHALL drive bus_addr = {addr[31:2],2'b00} from the granted requester.
REQ-013 Write grant SHALL drive bus_byteen as: word 1111; half at offset 0 0011, offset 2 1100; byte at offset k one-hot bit k.
REQ-014 Write grant SHALL replicate wdata: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word unchanged.
REQ-015 Writes SHALL complete in the grant cycle; FSM stays IDLE.
REQ-016 Read grant SHALL assert bus_rd, bus_byteen 0000, and move to RDWAIT.
REQ-017 In RDWAIT, SHALL register bus_rdata to the granted requester's rdata and pulse its rvalid for exactly one cycle following RDWAIT, then return to IDLE; rdata is the raw aligned word.
REQ-018 Misaligned request (half with addr[0]=1, word with addr[1:0]!=00, or size 11) SHALL still be granted, SHALL pulse exc in the grant cycle, SHALL drive bus_byteen 0000 and bus_rd 0, and SHALL NOT enter RDWAIT.
REQ-019 Ungranted requester SHALL see gnt low; arbiter SHALL NOT latch request; requester holds req until gnt.
REQ-020 With no req in IDLE, SHALL drive bus_byteen 0000, bus_rd 0, bus_addr/bus_wdata 0.
REQ-021 Throughput: back-to-back writes 1/cycle; reads occupy 2 cycles (grant + RDWAIT).

Reset
REQ-022 Reset SHALL force IDLE, round-robin pointer "d last" (m wins first tie), all rvalid 0, all rdata 0.
REQ-023 While reset high, SHALL hold all gnt, exc, bus_rd and bus_byteen at 0.
REQ-024 Reset during RDWAIT SHALL abandon the read: no rvalid pulse afterwards.

Configuration
REQ-025 With macro ARB_FIXED_PRIO_EN defined, SHALL grant m whenever m_req is high in IDLE (d only when m_req low); the pointer is unused.
REQ-026 Without ARB_FIXED_PRIO_EN, SHALL use round-robin per REQ-011.

Verification
REQ-027 After reset, m and d both write word to 0x10 and 0x20 same cycle -> cycle 1: m_gnt, bus_addr 0x10, byteen 1111; cycle 2: d_gnt, bus_addr 0x20.
REQ-028 m byte write 0xAB at 0x13 -> bus_addr 0x10, byteen 1000, bus_wdata 0xABABABAB.
REQ-029 d word read at 0x40, bus_rdata 0xDEADBEEF next cycle -> bus_rd 1 in grant cycle, d_rvalid 1 and d_rdata 0xDEADBEEF the following cycle; m_req during RDWAIT sees m_gnt 0.
REQ-030 m half write at 0x05 -> m_gnt 1, m_exc 1, byteen 0000, FSM remains IDLE.
REQ-031 Reset asserted during RDWAIT -> no rvalid pulse ever for that read; next tie grants m.
REQ-032 With ARB_FIXED_PRIO_EN, both requesting writes for 3 cycles -> m_gnt 3/3 cycles, d_gnt 0.
